// File: rtl/lab7_pkg.sv
// Shared types and glyph constants for the lab7 ALU display.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package lab7_pkg;

    typedef logic [7:0] seg_t;

    localparam int NUM_DIGITS = 4;

    // Active-low segment patterns, bit0 = a ... bit6 = g, bit7 = dp.
    localparam seg_t SEG_BLANK = 8'hFF;
    localparam seg_t SEG_MINUS = 8'hBF;

    localparam seg_t HEX_GLYPH [0:15] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

endpackage

// File: rtl/lab7_alu_display_glyph.sv
// Nibble to seven-segment glyph decoder with a blank override.
// Latency: combinational.
// Backpressure: none.
module sseg_glyph
    import lab7_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       blank,
    output seg_t       seg
);

    // Blank wins over the nibble; dp is left off here and applied by the caller.
    always_comb begin
        seg = blank ? SEG_BLANK : HEX_GLYPH[nib];
    end

endmodule

// File: rtl/lab7_alu_display.sv
// 4-bit add/sub shown on a 4-digit multiplexed common-anode display (hex operands, decimal result).
// Latency: 2 clk from operand/mode sample to sseg/an (input register, output register).
// Backpressure: none; free-running scan. Optional LAB7_OVF_DP_EN lights digit1 dp on signed overflow.
module lab7_alu_display
    import lab7_pkg::*;
#(
    parameter int REFRESH_BITS = 17,
    parameter int DEMO_TICKS   = 50_000_000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Sub,
    input  logic       RC,
    input  logic       Demo,
    input  logic       JAO,
    output logic [7:0] sseg,
    output logic [3:0] an
);

    localparam int                TICK_W    = (DEMO_TICKS > 1) ? $clog2(DEMO_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DEMO_TICKS - 1);

    // Registered copies of the switch inputs
    logic [3:0] a_q, b_q;
    logic       sub_q, rc_q, demo_q, jao_q;

    logic [REFRESH_BITS-1:0] refresh_cnt;
    logic [TICK_W-1:0]       tick_cnt;
    logic [7:0]              demo_val;

    logic [3:0] op_a, op_b, op_b_eff, sum, mag;
    logic [4:0] res5;
    logic       cout;
    logic [7:0] dec;
    logic [1:0] digit_idx;

    logic [3:0] dig_nib;
    logic       dig_blank, dig_minus, dig_dp;
    logic       ovf_dp;
    seg_t       glyph, seg_next;
    logic [3:0] an_next;

    // Binary to two decimal digits for 0..30; results are < 10 so 4-bit wrap arithmetic is exact.
    function automatic logic [7:0] to_dec(input logic [4:0] v);
        logic [3:0] tens, ones;
        if (v >= 5'd30) begin
            tens = 4'd3; ones = v[3:0] - 4'd14;
        end else if (v >= 5'd20) begin
            tens = 4'd2; ones = v[3:0] - 4'd4;
        end else if (v >= 5'd10) begin
            tens = 4'd1; ones = v[3:0] - 4'd10;
        end else begin
            tens = 4'd0; ones = v[3:0];
        end
        return {tens, ones};
    endfunction

    // Input register stage
    always_ff @(posedge clk) begin
        if (clr) begin
            a_q    <= '0;
            b_q    <= '0;
            sub_q  <= 1'b0;
            rc_q   <= 1'b0;
            demo_q <= 1'b0;
            jao_q  <= 1'b0;
        end else begin
            a_q    <= A;
            b_q    <= B;
            sub_q  <= Sub;
            rc_q   <= RC;
            demo_q <= Demo;
            jao_q  <= JAO;
        end
    end

    // Free-running refresh counter driving the digit scan
    always_ff @(posedge clk) begin
        if (clr) refresh_cnt <= '0;
        else     refresh_cnt <= refresh_cnt + 1'b1;
    end

    // Demo tick prescaler and operand-pair sweep; runs whether or not Demo is selected
    always_ff @(posedge clk) begin
        if (clr) begin
            tick_cnt <= '0;
            demo_val <= '0;
        end else if (en) begin
            if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
                demo_val <= demo_val + 8'd1;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

    assign op_a     = demo_q ? demo_val[7:4] : a_q;
    assign op_b     = demo_q ? demo_val[3:0] : b_q;
    assign op_b_eff = sub_q ? ~op_b : op_b;
    assign res5     = {1'b0, op_a} + {1'b0, op_b_eff} + {4'd0, sub_q};
    assign sum      = res5[3:0];
    assign cout     = res5[4];
    assign mag      = sum[3] ? (~sum + 4'd1) : sum;
    assign dec      = to_dec(sub_q ? {1'b0, sum} : res5);

`ifdef LAB7_OVF_DP_EN
    assign ovf_dp = (op_a[3] == op_b_eff[3]) && (sum[3] != op_a[3]);
`else
    assign ovf_dp = 1'b0;
`endif

    assign digit_idx = refresh_cnt[REFRESH_BITS-1 -: 2];

    // Choose what the currently scanned digit shows
    always_comb begin
        dig_nib   = 4'd0;
        dig_blank = 1'b1;
        dig_minus = 1'b0;
        dig_dp    = 1'b0;
        case (digit_idx)
            2'd3: begin
                dig_nib   = op_a;
                dig_blank = jao_q;
            end
            2'd2: begin
                dig_nib   = op_b;
                dig_blank = jao_q;
            end
            2'd1: begin
                if (rc_q) begin
                    dig_nib   = dec[7:4];
                    dig_blank = 1'b0;
                end else begin
                    dig_minus = sum[3];
                    dig_dp    = ovf_dp;
                end
            end
            default: begin
                dig_blank = 1'b0;
                if (rc_q) begin
                    dig_nib = dec[3:0];
                    dig_dp  = sub_q & ~cout;
                end else begin
                    dig_nib = mag;
                end
            end
        endcase
    end

    sseg_glyph u_glyph (
        .nib   (dig_nib),
        .blank (dig_blank),
        .seg   (glyph)
    );

    // Apply the minus sign and decimal point on top of the decoded glyph
    always_comb begin
        seg_next    = dig_minus ? SEG_MINUS : glyph;
        seg_next[7] = ~dig_dp;
        an_next     = ~(4'b0001 << digit_idx);
    end

    // Output register: segments and anode enable move together
    always_ff @(posedge clk) begin
        if (clr) begin
            sseg <= SEG_BLANK;
            an   <= 4'b1111;
        end else begin
            sseg <= seg_next;
            an   <= an_next;
        end
    end

endmodule

// File: tb/tb_lab7_alu_display.sv
// Directed self-checking bench for lab7_alu_display with a short scan and demo period.
// Latency: n/a.
// Backpressure: n/a.
module tb_lab7_alu_display;

    localparam int RB   = 4;
    localparam int DT   = 4;
    localparam int SCAN = 1 << RB;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       en = 1'b0;
    logic [3:0] A = 4'd0, B = 4'd0;
    logic       Sub = 1'b0, RC = 1'b1, Demo = 1'b0, JAO = 1'b0;
    logic [7:0] sseg;
    logic [3:0] an;

    int vectors     = 0;
    int miscompares = 0;
    int total_en    = 0;

    logic [7:0] dig [4];
    logic [7:0] hexg [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    lab7_alu_display #(.REFRESH_BITS(RB), .DEMO_TICKS(DT)) dut (
        .clk  (clk),
        .clr  (clr),
        .en   (en),
        .A    (A),
        .B    (B),
        .Sub  (Sub),
        .RC   (RC),
        .Demo (Demo),
        .JAO  (JAO),
        .sseg (sseg),
        .an   (an)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Let new inputs settle, then record one full scan of all four digits.
    task automatic capture();
        for (int k = 0; k < 4; k++) dig[k] = 8'hxx;
        repeat (3) @(negedge clk);
        for (int c = 0; c < SCAN + 2; c++) begin
            @(negedge clk);
            case (an)
                4'b1110: dig[0] = sseg;
                4'b1101: dig[1] = sseg;
                4'b1011: dig[2] = sseg;
                4'b0111: dig[3] = sseg;
                default: ;
            endcase
        end
    endtask

    task automatic check4(input string tag, input logic [7:0] d3, input logic [7:0] d2,
                          input logic [7:0] d1, input logic [7:0] d0);
        chk({tag, "_d3"}, dig[3], d3);
        chk({tag, "_d2"}, dig[2], d2);
        chk({tag, "_d1"}, dig[1], d1);
        chk({tag, "_d0"}, dig[0], d0);
    endtask

    task automatic run_en(input int n);
        en = 1'b1;
        repeat (n) @(negedge clk);
        en = 1'b0;
        total_en += n;
    endtask

    task automatic check_demo(input string tag);
        logic [7:0] dv;
        dv = 8'((total_en / DT) % 256);
        capture();
        chk({tag, "_d3"}, dig[3], hexg[dv[7:4]]);
        chk({tag, "_d2"}, dig[2], hexg[dv[3:0]]);
    endtask

    initial begin
        // Reset held for three cycles
        repeat (3) @(negedge clk);
        chk("rst_an", {4'h0, an}, 8'h0F);
        chk("rst_sseg", sseg, 8'hFF);

        // Scan order after release: one digit per SCAN/4 cycles, rightmost first
        clr = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            if (c == 1 || c == 4 || c == 5 || c == 9 || c == 13 || c == 17)
                chk($sformatf("scan_an_c%0d", c), {4'h0, an},
                    {4'h0, ~(4'b0001 << (((c - 1) / (SCAN / 4)) % 4))});
        end

        // Unsigned add: 11 + 1 = 12
        A = 4'b1011; B = 4'b0001; Sub = 1'b0; RC = 1'b1; Demo = 1'b0; JAO = 1'b0;
        capture();
        check4("uadd", 8'h83, 8'hF9, 8'hF9, 8'hA4);

        // Signed add: -5 + 1 = -4
        RC = 1'b0;
        capture();
        check4("sadd", 8'h83, 8'hF9, 8'hBF, 8'h99);

        // Signed sub: -5 - 1 = -6
        Sub = 1'b1;
        capture();
        check4("ssub", 8'h83, 8'hF9, 8'hBF, 8'h82);

        // Signed overflow: 7 + 1 wraps to -8
        A = 4'b0111; B = 4'b0001; Sub = 1'b0; RC = 1'b0;
        capture();
`ifdef LAB7_OVF_DP_EN
        check4("sovf", 8'hF8, 8'hF9, 8'h3F, 8'h80);
`else
        check4("sovf", 8'hF8, 8'hF9, 8'hBF, 8'h80);
`endif

        // Signed positive: 2 + 3 = 5, sign digit blank
        A = 4'd2; B = 4'd3;
        capture();
        check4("spos", 8'hA4, 8'hB0, 8'hFF, 8'h92);

        // Unsigned max sum: 15 + 15 = 30
        A = 4'hF; B = 4'hF; RC = 1'b1;
        capture();
        check4("umax", 8'h8E, 8'h8E, 8'hB0, 8'hC0);

        // Unsigned sub with borrow: 3 - 5 -> 14, dp on digit0
        A = 4'd3; B = 4'd5; Sub = 1'b1;
        capture();
        check4("uborrow", 8'hB0, 8'h92, 8'hF9, 8'h19);

        // Answer only: 3 - 2 = 01, no borrow
        A = 4'b0011; B = 4'b0010; JAO = 1'b1;
        capture();
        check4("jao", 8'hFF, 8'hFF, 8'hC0, 8'hF9);

        // Demo sweep with a 4-cycle tick
        JAO = 1'b0; Sub = 1'b0; Demo = 1'b1;
        capture();
        check_demo("demo0");
        run_en(4);
        check_demo("demo1");
        run_en(6);
        check_demo("demo2");
        run_en(1010);
        check_demo("demoFF");
        run_en(4);
        check_demo("demo_wrap");
        repeat (40) @(negedge clk);
        check_demo("demo_freeze");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
